// File: rtl/piece_queue_if.sv
// Piece-queue bus: RNG word, game-control strobes and the queue view.
interface piece_queue_if #(
  parameter int unsigned QUEUE_DEPTH = 4
);
  logic [31:0]              rand_in;
  logic                     start;
  logic                     pop;
  logic [2:0]               head_piece;
  logic                     head_valid;
  logic [3*QUEUE_DEPTH-1:0] preview;
  logic [3:0]               count;
  logic                     busy;

  modport master (
    output rand_in, start, pop,
    input  head_piece, head_valid, preview, count, busy
  );

  modport slave (
    input  rand_in, start, pop,
    output head_piece, head_valid, preview, count, busy
  );
endinterface

// File: rtl/piece_queue.sv
// Tetromino generator: NES draw-and-reroll over the RNG word, feeding a
// shift-based preview FIFO that the game logic pops from the head.
module piece_queue #(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  piece_queue_if.slave  bus
);

  localparam int unsigned PW        = 3;
  localparam int unsigned CW        = 4;
  localparam logic [PW-1:0] NONE    = 3'd7;

  typedef enum logic [1:0] {IDLE, DRAW, REROLL, FULL} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] q_q [QUEUE_DEPTH];
  logic [PW-1:0] q_d [QUEUE_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] last_q, last_d;
  logic          valid_q, busy_q;

  logic          push;
  logic [PW-1:0] push_val;
  logic          pop_ok;
  logic [CW-1:0] wr_idx;
  logic [PW-1:0] cand;
  logic [PW-1:0] l_base;
  logic [CW-1:0] sum;
  logic          unused_rand_hi;

  // Only the low three bits of the RNG word select a piece.
  assign cand           = bus.rand_in[2:0];
  assign unused_rand_hi = ^bus.rand_in[31:3];
  assign l_base         = (last_q == NONE) ? 3'd0 : last_q;
  assign sum            = CW'(cand) + CW'(l_base);

  // Next-state, queue shift/insert and history update.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    count_d  = count_q;
    last_d   = last_q;
    push     = 1'b0;
    push_val = cand;
    pop_ok   = 1'b0;
    wr_idx   = count_q;

    if (bus.start) begin
      state_d = DRAW;
      count_d = '0;
      last_d  = NONE;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_d[i] = NONE;
    end else begin
      pop_ok = bus.pop && (count_q != '0);

      case (state_q)
        DRAW: begin
          if (cand != NONE && cand != last_q) begin
            push     = 1'b1;
            push_val = cand;
          end else begin
            state_d = REROLL;
          end
        end
        REROLL: begin
          push     = 1'b1;
          push_val = (sum >= 4'd7) ? PW'(sum - 4'd7) : PW'(sum);
        end
        FULL: begin
          if (pop_ok) state_d = DRAW;
        end
        default: ;
      endcase

      if (pop_ok) begin
        for (int unsigned i = 0; i + 1 < QUEUE_DEPTH; i++) q_d[i] = q_q[i+1];
        q_d[QUEUE_DEPTH-1] = NONE;
        count_d = count_q - 4'd1;
        wr_idx  = count_q - 4'd1;
      end

      if (push) begin
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
          if (CW'(i) == wr_idx) q_d[i] = push_val;
        end
        count_d = count_d + 4'd1;
        last_d  = push_val;
        state_d = (count_d == CW'(QUEUE_DEPTH)) ? FULL : DRAW;
      end
    end
  end

  // State, queue and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= NONE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_q[i] <= NONE;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      valid_q <= (count_d != '0);
      busy_q  <= (state_d == DRAW) || (state_d == REROLL);
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_q[i] <= q_d[i];
    end
  end

  assign bus.head_piece = q_q[0];
  assign bus.head_valid = valid_q;
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;

  for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_preview
    assign bus.preview[PW*g +: PW] = q_q[g];
  end

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: vector table plus corner-case sequences.
module tb_piece_queue;

  localparam int unsigned QUEUE_DEPTH = 4;

  logic clk;
  logic reset;

  piece_queue_if #(.QUEUE_DEPTH(QUEUE_DEPTH)) bus ();

  piece_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        pp;
    logic [2:0]  rv;
    logic [3:0]  cnt;
    logic [2:0]  head;
    logic        valid;
    logic        busy;
    logic [11:0] prev;
  } vec_t;

  int checks;
  int errors;
  vec_t tbl [15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic pp, input logic [2:0] rv,
                              input logic [3:0] cnt, input logic [2:0] head,
                              input logic busy, input logic [11:0] prev);
    vec_t v;
    v.rst = 1'b0; v.st = st; v.pp = pp; v.rv = rv;
    v.cnt = cnt; v.head = head; v.valid = (cnt != 4'd0); v.busy = busy; v.prev = prev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic [2:0] rv);
    logic [31:0] w;
    @(negedge clk);
    w = $urandom();
    w[2:0] = rv;
    reset = r;
    bus.start = s;
    bus.pop = p;
    bus.rand_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] cnt, input logic [2:0] head,
                           input logic busy, input logic [11:0] prev);
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    chk({tag, ".head"}, 32'(bus.head_piece), 32'(head));
    chk({tag, ".valid"}, 32'(bus.head_valid), 32'(cnt != 4'd0));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, ".preview"}, 32'(bus.preview), 32'(prev));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pop = 1'b0;
    bus.rand_in = '0;

    // Reroll path with rand=3, then pop/refill and pop held on a full queue.
    tbl[0]  = mk(1, 0, 3, 0, 7, 1, 12'hFFF);
    tbl[1]  = mk(0, 0, 3, 1, 3, 1, 12'hFFB);
    tbl[2]  = mk(0, 0, 3, 1, 3, 1, 12'hFFB);
    tbl[3]  = mk(0, 0, 3, 2, 3, 1, 12'hFF3);
    tbl[4]  = mk(0, 0, 3, 3, 3, 1, 12'hEF3);
    tbl[5]  = mk(0, 0, 3, 3, 3, 1, 12'hEF3);
    tbl[6]  = mk(0, 0, 3, 4, 3, 0, 12'hCF3);
    tbl[7]  = mk(0, 0, 3, 4, 3, 0, 12'hCF3);
    tbl[8]  = mk(0, 1, 5, 3, 6, 1, 12'hF9E);
    tbl[9]  = mk(0, 0, 5, 4, 6, 0, 12'hB9E);
    tbl[10] = mk(0, 1, 2, 3, 3, 1, 12'hF73);
    tbl[11] = mk(0, 1, 2, 3, 6, 1, 12'hEAE);
    tbl[12] = mk(0, 1, 1, 3, 5, 1, 12'hE55);
    tbl[13] = mk(0, 1, 4, 3, 2, 1, 12'hF0A);
    tbl[14] = mk(0, 0, 0, 4, 2, 0, 12'h10A);

    // Reset with random control inputs, then idle.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      check_all("reset", 4'd0, 3'd7, 1'b0, 12'hFFF);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
      check_all("idle", 4'd0, 3'd7, 1'b0, 12'hFFF);
    end

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].pp, tbl[i].rv);
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].head, tbl[i].busy, tbl[i].prev);
    end

    // start together with pop during REROLL flushes and clears history.
    step(0, 1, 0, 3); check_all("mid.start", 4'd0, 3'd7, 1'b1, 12'hFFF);
    step(0, 0, 0, 3); check_all("mid.push", 4'd1, 3'd3, 1'b1, 12'hFFB);
    step(0, 0, 0, 3); check_all("mid.draw_rej", 4'd1, 3'd3, 1'b1, 12'hFFB);
    step(0, 1, 1, 3); check_all("mid.flush", 4'd0, 3'd7, 1'b1, 12'hFFF);
    step(0, 0, 0, 3); check_all("mid.last_cleared", 4'd1, 3'd3, 1'b1, 12'hFFB);

    // pop on an empty queue is ignored, after reset and after start.
    step(1, 0, 0, 0); check_all("empty.reset", 4'd0, 3'd7, 1'b0, 12'hFFF);
    step(0, 0, 1, 0); check_all("empty.pop_idle", 4'd0, 3'd7, 1'b0, 12'hFFF);
    step(0, 1, 0, 7); check_all("empty.start", 4'd0, 3'd7, 1'b1, 12'hFFF);
    step(0, 0, 1, 7); check_all("empty.pop_draw", 4'd0, 3'd7, 1'b1, 12'hFFF);

    // Value 7 always rerolls to 0; duplicates accepted.
    step(0, 1, 0, 7); check_all("seven.start", 4'd0, 3'd7, 1'b1, 12'hFFF);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 7);
      chk($sformatf("seven%0d.count", k), 32'(bus.count), 32'(k / 2));
      if (k >= 2) chk($sformatf("seven%0d.head", k), 32'(bus.head_piece), 32'd0);
    end
    check_all("seven.full", 4'd4, 3'd0, 1'b0, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_queue.md
# piece_queue

Consumer side of the hardware random source: samples the free-running 32-bit random word each cycle and turns it into a stream of tetromino IDs using the NES draw-and-reroll rule. Holds the IDs in a small preview FIFO that the game logic pops one piece at a time. Sits between the RNG and the game-state / next-piece display logic.

## Interface
- QUEUE_DEPTH, 4, number of queued pieces (head plus previews), legal range 2..8
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- rand_in  input  32  random word from the RNG, expected to change every cycle; only bits [2:0] are used
- start  input  1  one-cycle pulse that begins a new game: flush the queue, clear history, start filling
- pop  input  1  consumer takes the head piece; ignored when head_valid=0
- head_piece  output  3  queue entry 0, piece ID 0..6 (T,J,Z,O,S,L,I); 7 when empty
- head_valid  output  1  count != 0
- preview  output  3*QUEUE_DEPTH  entry i at bits [3i+2:3i], entry 0 = head; unused entries read 7
- count  output  4  number of valid entries, 0..QUEUE_DEPTH
- busy  output  1  state is DRAW or REROLL

## Operation
- Internal state: queue entries, count, last (3 bits, 7 = none), FSM state.
- FSM states are IDLE, DRAW, REROLL and FULL.
  - IDLE: no generation. Stays in IDLE until start.
  - DRAW: cand = rand_in[2:0].
    - If cand != 7 and cand != last: push cand and set last <= cand.
    - Otherwise push nothing and go to REROLL.
  - REROLL: sum = rand_in[2:0] + L (4-bit), where L = last, or 0 when last = 7.
    - Result r = sum - 7 if sum >= 7, else sum. Result range is always 0..6.
    - Push r and set last <= r. r may equal the previous last; a duplicate is accepted.
  - After a push, the next state is FULL if the post-cycle count equals QUEUE_DEPTH, else DRAW.
  - FULL: no generation. Goes to DRAW in the cycle a pop is accepted.
- Queue is shift-based:
  - A pop shifts entries i+1 into i, and the vacated tail entry reads 7.
  - A push writes at index count, or at index count-1 if a pop is accepted in the same cycle.
- Simultaneous push and pop: both happen and count is unchanged.
- start in any state, including mid-REROLL and simultaneously with pop:
  - Next cycle: count=0, all entries read 7, last=7, state DRAW.
  - start wins over pop and over any push in that cycle.
- pop while count=0: ignored, no state change.
- reset (highest priority, any state): next cycle state IDLE, count=0, entries 7, last=7.
  - Outputs after reset: head_piece=7, head_valid=0, preview all 7s, count=0, busy=0.

## Timing
- All outputs are registered and change only on the clk edge.
- start sampled at edge 0 gives DRAW in cycle 1.
- A push decided in cycle n is visible on head_piece/preview/count in cycle n+1.
- Piece latency: 1 cycle on a direct accept, 2 cycles when a reroll is needed.
- pop sampled at edge n gives the shifted head in cycle n+1.
- Pop in FULL at cycle n gives DRAW in n+1 and the refill visible in n+2.
- REROLL uses the rand_in value of its own cycle, not the value from the DRAW cycle.

## Test plan
- Reset behaviour: assert reset 2 cycles with random pop/start, then hold both inputs low for 10 cycles -> head_valid=0, count=0, head_piece=7, preview all 7s, busy=0 throughout.
- Reroll path: rand_in[2:0] held at 3, start pulse at cycle 0.
  - Counts: count=1 (head 3) at cycle 2, 2 at cycle 4, 3 at cycle 5, 4 at cycle 7.
  - Final queue: preview entries = 3,6,3,6; state FULL, busy=0 from cycle 7.
- Value-7 path: rand_in[2:0] held at 7, start -> every draw rerolls (7+0-7=0) -> queue fills to 0,0,0,0 after 8 cycles with duplicates accepted.
- Pop and refill: from the full queue 3,6,3,6 with rand_in[2:0]=5, pop one cycle.
  - Next cycle: head=6, count=3.
  - Following cycle: 5 pushed at the tail, queue 6,3,6,5, count=4.
  - Pop held high with the queue full: count stays constant, one piece consumed per cycle.
- start mid-REROLL: assert start in the REROLL cycle alongside pop -> next cycle count=0, head_valid=0, last=7, DRAW; no stale push appears.
- pop while empty: pop with count=0 (after reset, or right after start) -> no change, count=0, head_piece=7.
